// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Control bundle between the multicycle datapath and its
//                sequencing controller. The datapath (master) supplies the
//                opcode, ALU zero flag and memory handshake; the controller
//                (slave) returns the per-cycle control strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if #(
    parameter int OPW = 5,
    parameter int ACW = 4
);
    logic [OPW-1:0] op;
    logic           zero;
    logic           mem_ready;
    logic           iord;
    logic           irwrite;
    logic           memwrite;
    logic           regwrite;
    logic           regdst;
    logic           memtoreg;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     pcsrc;
    logic           pcen;
    logic [ACW-1:0] alucontrol;
    logic           halted;
    logic           illegal_op;
    logic [3:0]     state;

    modport master (
        output op, zero, mem_ready,
        input  iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, halted,
               illegal_op, state
    );

    modport slave (
        input  op, zero, mem_ready,
        output iord, irwrite, memwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, halted,
               illegal_op, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Moore-style sequencer for the multicycle 5-bit-opcode CPU.
//                Drives one set of datapath strobes per cycle, stalls on the
//                memory handshake and parks the core on HALT or an undefined
//                opcode until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int OPW = 5,
    parameter int ACW = 4
) (
    input  wire logic                clk,
    input  wire logic                reset,
    multicycle_controller_if.slave   bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    // Opcode map
    localparam logic [OPW-1:0] c_OP_RMAX = OPW'(5'b01000);
    localparam logic [OPW-1:0] c_OP_ADDI = OPW'(5'b01001);
    localparam logic [OPW-1:0] c_OP_ANDI = OPW'(5'b01010);
    localparam logic [OPW-1:0] c_OP_ORI  = OPW'(5'b01011);
    localparam logic [OPW-1:0] c_OP_LW   = OPW'(5'b01100);
    localparam logic [OPW-1:0] c_OP_SW   = OPW'(5'b01101);
    localparam logic [OPW-1:0] c_OP_BEQ  = OPW'(5'b01110);
    localparam logic [OPW-1:0] c_OP_BNE  = OPW'(5'b01111);
    localparam logic [OPW-1:0] c_OP_J    = OPW'(5'b10000);
    localparam logic [OPW-1:0] c_OP_HALT = OPW'(5'b11111);

    // ALU operation codes
    localparam logic [ACW-1:0] c_ALU_ADD = ACW'(4'b0000);
    localparam logic [ACW-1:0] c_ALU_SUB = ACW'(4'b0001);
    localparam logic [ACW-1:0] c_ALU_AND = ACW'(4'b0010);
    localparam logic [ACW-1:0] c_ALU_OR  = ACW'(4'b0011);

    state_t         r_state;
    state_t         w_next;
    logic           r_illegal;

    logic           w_is_rtype;
    logic           w_is_itype;
    logic           w_is_mem;
    logic           w_is_branch;
    logic           w_is_jump;
    logic           w_is_halt;
    logic           w_is_illegal;

    logic           w_iord;
    logic           w_irwrite;
    logic           w_memwrite;
    logic           w_regwrite;
    logic           w_regdst;
    logic           w_memtoreg;
    logic           w_alusrca;
    logic [1:0]     w_alusrcb;
    logic [1:0]     w_pcsrc;
    logic           w_pcen;
    logic [ACW-1:0] w_alucontrol;
    logic           w_halted;

    // Opcode classification; only meaningful while op reflects the loaded IR
    always_comb begin
        w_is_rtype   = (bus.op <= c_OP_RMAX);
        w_is_itype   = (bus.op == c_OP_ADDI) || (bus.op == c_OP_ANDI) ||
                       (bus.op == c_OP_ORI);
        w_is_mem     = (bus.op == c_OP_LW) || (bus.op == c_OP_SW);
        w_is_branch  = (bus.op == c_OP_BEQ) || (bus.op == c_OP_BNE);
        w_is_jump    = (bus.op == c_OP_J);
        w_is_halt    = (bus.op == c_OP_HALT);
        w_is_illegal = !(w_is_rtype || w_is_itype || w_is_mem ||
                         w_is_branch || w_is_jump || w_is_halt);
    end

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && w_is_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and Moore outputs; reset masks every write strobe so an
    // aborted access cannot corrupt architectural state
    always_comb begin
        w_next       = r_state;
        w_iord       = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_pcen       = 1'b0;
        w_alucontrol = c_ALU_ADD;
        w_halted     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = bus.mem_ready;
                w_pcen    = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                w_alusrcb = 2'b11;
                if (w_is_mem) begin
                    w_next = S_MEMADR;
                end else if (w_is_rtype) begin
                    w_next = S_EXECUTE;
                end else if (w_is_itype) begin
                    w_next = S_IEXEC;
                end else if (w_is_branch) begin
                    w_next = S_BRANCH;
                end else if (w_is_jump) begin
                    w_next = S_JUMP;
                end else begin
                    w_next = S_HALT;
                end
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (bus.op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                if (bus.mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                w_alusrca    = 1'b1;
                w_alucontrol = ACW'(bus.op[3:0]);
                w_next       = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_IEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                if (bus.op == c_OP_ANDI) begin
                    w_alucontrol = c_ALU_AND;
                end else if (bus.op == c_OP_ORI) begin
                    w_alucontrol = c_ALU_OR;
                end else begin
                    w_alucontrol = c_ALU_ADD;
                end
                w_next = S_IWB;
            end
            S_IWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                // Compare regA-regB; take target held in ALUOut
                w_alusrca    = 1'b1;
                w_alucontrol = c_ALU_SUB;
                w_pcsrc      = 2'b01;
                w_pcen       = (bus.op == c_OP_BNE) ? !bus.zero : bus.zero;
                w_next       = S_FETCH;
            end
            S_JUMP: begin
                w_pcsrc = 2'b10;
                w_pcen  = 1'b1;
                w_next  = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (reset) begin
            w_pcen     = 1'b0;
            w_irwrite  = 1'b0;
            w_memwrite = 1'b0;
            w_regwrite = 1'b0;
        end
    end

    assign bus.iord       = w_iord;
    assign bus.irwrite    = w_irwrite;
    assign bus.memwrite   = w_memwrite;
    assign bus.regwrite   = w_regwrite;
    assign bus.regdst     = w_regdst;
    assign bus.memtoreg   = w_memtoreg;
    assign bus.alusrca    = w_alusrca;
    assign bus.alusrcb    = w_alusrcb;
    assign bus.pcsrc      = w_pcsrc;
    assign bus.pcen       = w_pcen;
    assign bus.alucontrol = w_alucontrol;
    assign bus.halted     = w_halted;
    assign bus.illegal_op = r_illegal;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-style FSM controller for the multicycle version of the 5-bit-opcode CPU. It sequences a shared datapath with a single ALU, a unified instruction/data memory and IR/ALUOut registers, producing one set of control strobes per cycle. A mem_ready handshake lets memory accesses stall. Illegal opcodes and HALT park the core.

Parameters:
OPW, 5, opcode width
ACW, 4, alucontrol width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
op  input  OPW  opcode from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
iord  output  1  memory address select (0=PC, 1=ALUOut)
irwrite  output  1  IR load enable
memwrite  output  1  memory write strobe
regwrite  output  1  register file write enable
regdst  output  1  dest reg select (1=rd, 0=rt)
memtoreg  output  1  writeback select (1=memory data)
alusrca  output  1  ALU A select (0=PC, 1=regA)
alusrcb  output  2  ALU B select (00=regB, 01=const 4, 10=signimm, 11=signimm<<2)
pcsrc  output  2  PC source (00=ALU result, 01=ALUOut, 10=jump target)
pcen  output  1  PC write enable
alucontrol  output  ACW  ALU operation
halted  output  1  core parked in HALT
illegal_op  output  1  sticky: halted due to an undefined opcode
state  output  4  current state (debug)

Behaviour:
- Opcodes: 00000-01000 R-type (alucontrol=op[3:0]); 01001 ADDI; 01010 ANDI; 01011 ORI; 01100 LW; 01101 SW; 01110 BEQ; 01111 BNE; 10000 J; 11111 HALT; all others illegal.
- alucontrol codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 nor, 0110 slt, 0111 sll, 1000 srl.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, IEXEC=8, IWB=9, BRANCH=10, JUMP=11, HALT=12.
- Default output value is 0 in every state unless listed below.
- FETCH: alusrcb=01, alucontrol=add, irwrite=pcen=mem_ready. Stays in FETCH while !mem_ready. Goes to DECODE on mem_ready.
- DECODE: alusrcb=11, alucontrol=add (branch target into ALUOut). Next state by opcode:
  - LW/SW: MEMADR
  - R-type: EXECUTE
  - ADDI/ANDI/ORI: IEXEC
  - BEQ/BNE: BRANCH
  - J: JUMP
  - HALT: HALT
  - illegal: HALT, with illegal_op set at that edge
- MEMADR: alusrca=1, alusrcb=10, alucontrol=add. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR: iord=1, memwrite=1, held while waiting. Goes to FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol=op[3:0]. Goes to ALUWB.
- ALUWB: regdst=1, regwrite=1. Goes to FETCH.
- IEXEC: alusrca=1, alusrcb=10, alucontrol=add/and/or for ADDI/ANDI/ORI. Goes to IWB.
- IWB: regdst=0, regwrite=1. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01.
  - pcen=zero for BEQ, pcen=~zero for BNE, combinational from zero in this state.
  - Goes to FETCH.
- JUMP: pcsrc=10, pcen=1. Goes to FETCH.
- HALT: all enables 0, halted=1. Stays in HALT until reset.
- op is sampled only in DECODE through BRANCH/IEXEC/EXECUTE. op is assumed stable after IR load; the controller does not latch it.
- Cycle counts with mem_ready tied high: R-type 4, I-type 4, LW 5, SW 4, BEQ/BNE 3, J 3. Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- Reset:
  - While reset=1, pcen, irwrite, memwrite and regwrite are forced 0.
  - At the edge: state<=FETCH, illegal_op<=0.
  - After reset, outputs equal the FETCH values (alusrcb=01, alucontrol=0000, everything else 0, halted=0).
  - Reset mid-operation (including MEMWR while waiting, and HALT) aborts with no further writes.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.

Test Plan:
- Reset, op=00000 (add), mem_ready=1, zero=0 -> states 0,1,6,7,0. regwrite=1 and regdst=1 only in cycle 4. pcen=irwrite=1 only in cycle 1.
- LW (01100), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. iord=1 for the 3 MEMRD cycles. memtoreg=regwrite=1 in MEMWB.
- BEQ (01110) with zero=1, then BEQ with zero=0, then BNE (01111) with zero=0 -> pcen=1, 0, 1 in the BRANCH cycle. pcsrc=01 and alucontrol=0001 each time.
- Illegal op 10101 -> DECODE then HALT. halted=1 and illegal_op=1 hold for 20+ cycles with all enables 0. Reset clears both, state=0.
- SW (01101) with mem_ready=0, reset asserted during the 2nd MEMWR cycle -> memwrite=0 during the reset cycle, state=0 next cycle, no regwrite.
- J (10000) then HALT (11111) -> pcsrc=10 and pcen=1 for one cycle. Then after FETCH/DECODE, halted=1 and illegal_op=0.
